// File: rtl/mmio_mailbox_pkg.sv
// rtl/mmio_mailbox_pkg.sv - register map, bit positions and status packing for mmio_mailbox
package mmio_mailbox_pkg;

  // Register offsets selected by a[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  // STATUS bit positions
  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_TX_OVF   = 4;
  localparam int STAT_RX_UDF   = 5;
  localparam int STAT_TX_COUNT = 8;
  localparam int STAT_RX_COUNT = 16;

  // CONTROL bit positions
  localparam int CTRL_CLR_ERR = 0;
  localparam int CTRL_FLUSH   = 1;

  // Assemble the STATUS word; counts arrive already zero-extended to 8 bits
  function automatic logic [31:0] pack_status(
    input logic       tx_full,
    input logic       tx_empty,
    input logic       rx_full,
    input logic       rx_empty,
    input logic       tx_ovf,
    input logic       rx_udf,
    input logic [7:0] tx_count,
    input logic [7:0] rx_count
  );
    logic [31:0] s;
    s = '0;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_TX_EMPTY] = tx_empty;
    s[STAT_RX_FULL]  = rx_full;
    s[STAT_RX_EMPTY] = rx_empty;
    s[STAT_TX_OVF]   = tx_ovf;
    s[STAT_RX_UDF]   = rx_udf;
    s[STAT_TX_COUNT +: 8] = tx_count;
    s[STAT_RX_COUNT +: 8] = rx_count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_mailbox_sync_fifo.sv
// rtl/mmio_mailbox_sync_fifo.sv - synchronous FIFO with flush and zeroed head when empty
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rptr];

  // Full/empty are judged on the count at the start of the cycle; flush overrides both
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Storage write; no reset needed since reads are gated by the count
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_mailbox.sv
// rtl/mmio_mailbox.sv - memory-mapped TX/RX mailbox on the data-memory bus
module mmio_mailbox
  import mmio_mailbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  output logic        rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    sel;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          ctrl_wr, clr_err, flush;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [31:0]   rx_dout;
  logic          tx_ovf, rx_udf;
  logic [31:0]   status;
  logic          unused_addr_bits;

  assign sel              = a[3:2];
  assign unused_addr_bits = ^{a[31:4], a[1:0]};

  assign tx_push = cs & we & (sel == REG_TXDATA);
  assign rx_pop  = cs & re & ~we & (sel == REG_RXDATA);
  assign ctrl_wr = cs & we & (sel == REG_CONTROL);
  assign clr_err = ctrl_wr & wd[CTRL_CLR_ERR];
  assign flush   = ctrl_wr & wd[CTRL_FLUSH];

  // Stream handshakes use only registered FIFO state on our side
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .din   (wd),
    .dout  (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush),
    .din   (rx_data),
    .dout  (rx_dout),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Sticky error flags; a CONTROL clear and a new error never share a cycle on this bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (clr_err)                 tx_ovf <= 1'b0;
      else if (tx_push & tx_full)  tx_ovf <= 1'b1;
      if (clr_err)                 rx_udf <= 1'b0;
      else if (rx_pop & rx_empty)  rx_udf <= 1'b1;
    end
  end

  assign status = pack_status(tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_udf,
                              8'(tx_count), 8'(rx_count));

  // Load data mux, combinational like the data memory read port
  always_comb begin
    rd = '0;
    case (sel)
      REG_RXDATA: rd = rx_dout;
      REG_STATUS: rd = status;
      default:    rd = '0;
    endcase
  end

endmodule
